iob_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one IOb native slave port (e.g. the external-memory data bus) between N_MASTERS IOb native masters (CPU data bus, accelerator/DMA engines).
- Grants one master at a time.
- Holds the grant until the slave completes the transaction, then advances priority.
- Sits between the master-side buses and the ext_mem data-bus port, below the system bus split.

---
 rtl/iob_rr_arbiter_pkg.sv | 16 +
 rtl/iob_rr_prio_enc.sv | 27 ++
 rtl/iob_rr_arbiter.sv | 108 ++++++++++
 tb/tb_iob_rr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_rr_arbiter_pkg.sv
// iob_rr_arbiter_pkg: shared state encodings, abort data word and field slice helper
package iob_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    // Low bit of master i's field in a packed per-master bus of field width w
    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// iob_rr_prio_enc: rotating priority encoder, first requester at or after ptr wins
module iob_rr_prio_enc #(
    parameter int N_MASTERS = 2,
    parameter int PW = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [N_MASTERS-1:0] win,
    output logic                 any
);

    logic found;

    // Scan requesters in order ptr, ptr+1, ... wrapping, keeping the first hit
    always_comb begin
        win   = '0;
        found = 1'b0;
        any   = |req;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && req[(int'(ptr) + k) % N_MASTERS]) begin
                win[(int'(ptr) + k) % N_MASTERS] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin share of one IOb slave among N_MASTERS masters; IOB_ARB_TIMEOUT_EN adds a watchdog
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          timeout_err
);

    localparam int PW = $clog2(N_MASTERS);
    localparam int SW = DATA_W / 8;

    arb_state_t           state, state_nxt;
    logic [PW-1:0]        ptr, ptr_nxt, idx, idx_nxt, win_idx;
    logic [N_MASTERS-1:0] win;
    logic                 any, busy, done, abort;

    assign busy = state == ARB_BUSY;
    assign done = busy && (s_ready || abort);

    iob_rr_prio_enc #(.N_MASTERS(N_MASTERS), .PW(PW)) u_prio (
        .req(m_valid),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    // Convert the one-hot winner to the index that is registered as owner
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (win[i]) win_idx = PW'(i);
    end

`ifdef IOB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;

    assign abort = busy && !s_ready && cnt == CW'(TIMEOUT - 1);

    // Watchdog counts BUSY cycles from zero; the error flag is sticky until reset
    always_ff @(posedge clk) begin
        cnt         <= (rst || !busy) ? '0 : cnt + 1'b1;
        timeout_err <= rst ? 1'b0 : (timeout_err || abort);
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = TIMEOUT < 0;
`endif

    // State, pointer and owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            idx   <= idx_nxt;
        end
    end

    // Grant on any request when idle; release and advance the pointer past the owner on completion
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        if (!busy && any) begin
            state_nxt = ARB_BUSY;
            idx_nxt   = win_idx;
        end
        if (done) begin
            state_nxt = ARB_IDLE;
            ptr_nxt   = (idx == PW'(N_MASTERS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Route the owner's request to the slave and the slave's response back to the owner
    always_comb begin
        grant   = busy ? (N_MASTERS'(1) << idx) : '0;
        s_valid = busy && m_valid[idx];
        s_addr  = busy ? m_addr[slice_lo(int'(idx), ADDR_W) +: ADDR_W] : '0;
        s_wdata = busy ? m_wdata[slice_lo(int'(idx), DATA_W) +: DATA_W] : '0;
        s_wstrb = busy ? m_wstrb[slice_lo(int'(idx), SW) +: SW] : '0;
        m_ready = done ? grant : '0;
        m_rdata = !done ? '0 : abort ? DATA_W'(ARB_ABORT_DATA) : s_rdata;
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// tb_iob_rr_arbiter: directed checks of a 3-master arbiter (TIMEOUT=16 when IOB_ARB_TIMEOUT_EN)
module tb_iob_rr_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_valid;
    logic [N*32-1:0] m_addr;
    logic [N*32-1:0] m_wdata;
    logic [N*4-1:0]  m_wstrb;
    logic [31:0]   m_rdata;
    logic [N-1:0]  m_ready;
    logic          s_valid;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_rdata;
    logic          s_ready;
    logic [N-1:0]  grant;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_valid = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge of an idle cycle with requests posted; returns at the next idle cycle
    task automatic serve(input logic [N-1:0] exp_g, input logic [31:0] rd);
        check("idle_gap_grant", grant, 0);
        @(negedge clk);
        check("serve_grant", grant, exp_g);
        check("serve_s_valid", s_valid, 1);
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        check("serve_m_ready", m_ready, exp_g);
        check("serve_m_rdata", m_rdata, rd);
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = '0;
    endtask

    initial begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_m_ready", m_ready, 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_timeout_err", timeout_err, 0);

        // single master read with a 3-cycle slave
        m_addr[0 +: 32] = 32'h100;
        m_valid = 3'b001;
        #1;
        check("single_latency_s_valid", s_valid, 0);
        @(negedge clk);
        check("single_s_valid", s_valid, 1);
        check("single_s_addr", s_addr, 32'h100);
        check("single_s_wstrb", s_wstrb, 0);
        check("single_grant", grant, 3'b001);
        repeat (2) begin
            @(negedge clk);
            check("single_wait_m_ready", m_ready, 0);
        end
        s_ready = 1'b1;
        s_rdata = 32'h12345678;
        #1;
        check("single_m_ready", m_ready, 3'b001);
        check("single_m_rdata", m_rdata, 32'h12345678);
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = '0;
        m_valid = '0;
        check("single_grant_after", grant, 0);
        check("single_m_ready_after", m_ready, 0);

        // contention between masters 0 and 1: 0,1,0,1
        do_reset();
        m_valid = 3'b011;
        serve(3'b001, 32'h11);
        serve(3'b010, 32'h22);
        serve(3'b001, 32'h33);
        serve(3'b010, 32'h44);
        m_valid = '0;

        // write forwarding from master 1
        do_reset();
        m_addr[32 +: 32]  = 32'h2000;
        m_wdata[32 +: 32] = 32'hCAFEF00D;
        m_wstrb[4 +: 4]   = 4'b0011;
        m_addr[0 +: 32]   = 32'h5555;
        m_wdata[0 +: 32]  = 32'h5A5A5A5A;
        m_wstrb[0 +: 4]   = 4'b1111;
        m_valid = 3'b010;
        @(negedge clk);
        check("wr_grant", grant, 3'b010);
        check("wr_s_addr", s_addr, 32'h2000);
        check("wr_s_wdata", s_wdata, 32'hCAFEF00D);
        check("wr_s_wstrb", s_wstrb, 4'b0011);
        check("wr_m_ready_wait", m_ready, 0);
        s_ready = 1'b1;
        #1;
        check("wr_m_ready", m_ready, 3'b010);
        @(negedge clk);
        s_ready = 1'b0;
        m_valid = '0;
        check("wr_m_ready_after", m_ready, 0);

        // wrap-around with all three requesting
        do_reset();
        m_valid = 3'b111;
        serve(3'b001, 32'hA0);
        serve(3'b010, 32'hA1);
        serve(3'b100, 32'hA2);
        serve(3'b001, 32'hA3);
        serve(3'b010, 32'hA4);
        serve(3'b100, 32'hA5);
        m_valid = '0;

        // reset while master 1 owns the bus with the slave pending
        do_reset();
        m_valid = 3'b001;
        serve(3'b001, 32'h1);
        m_valid = 3'b010;
        @(negedge clk);
        check("mid_grant_before", grant, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_s_valid", s_valid, 0);
        rst = 1'b0;
        m_valid = '0;
        s_ready = 1'b1;
        s_rdata = 32'hBAD0BAD0;
        #1;
        check("mid_late_m_ready", m_ready, 0);
        check("mid_late_m_rdata", m_rdata, 0);
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = '0;
        m_valid = 3'b011;
        serve(3'b001, 32'h77);
        m_valid = '0;

`ifdef IOB_ARB_TIMEOUT_EN
        // slave never responds: abort on the 16th busy cycle
        do_reset();
        m_valid = 3'b001;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_wait_m_ready", m_ready, 0);
        end
        @(negedge clk);
        check("to_m_ready", m_ready, 3'b001);
        check("to_m_rdata", m_rdata, 32'hDEADBEEF);
        check("to_err_before", timeout_err, 0);
        m_valid = '0;
        @(negedge clk);
        check("to_err_set", timeout_err, 1);
        check("to_grant_released", grant, 0);
        s_ready = 1'b1;
        #1;
        check("to_late_m_ready", m_ready, 0);
        @(negedge clk);
        s_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("to_err_sticky", timeout_err, 1);
        do_reset();
        check("to_err_cleared", timeout_err, 0);
`else
        check("no_timeout_err", timeout_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
